// File: rtl/int_issue_select_pkg.sv
// Shared sizing constants for the integer issue queue select/issue logic.
package int_issue_select_pkg;

   localparam int INT_QUEUE_SIZE       = 8;
   localparam int INT_QUEUE_SIZE_INDEX = $clog2(INT_QUEUE_SIZE);

endpackage

// File: rtl/int_issue_select_age_matrix_select.sv
// Age matrix for the integer issue queue plus the oldest-ready winner pick.
// r_age[i][j] = 1 means entry i is older than entry j; the diagonal stays 0.
module int_issue_select_age_matrix_select
   import int_issue_select_pkg::*;
#(
   parameter int QUEUE_SIZE  = INT_QUEUE_SIZE,
   parameter int QUEUE_INDEX = INT_QUEUE_SIZE_INDEX
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [QUEUE_SIZE-1:0]  i_entry_occupied,
   input  logic [QUEUE_SIZE-1:0]  i_entry_ready,
   input  logic                   i_alloc0_valid,
   input  logic [QUEUE_INDEX-1:0] i_alloc0_idx,
   input  logic                   i_alloc1_valid,
   input  logic [QUEUE_INDEX-1:0] i_alloc1_idx,
   input  logic                   i_flush,
   output logic                   o_any_cand,
   output logic [QUEUE_INDEX-1:0] o_win_idx
);

   logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] r_age;
   logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] w_age_next;
   logic [QUEUE_SIZE-1:0]                 w_cand;
   logic [QUEUE_SIZE-1:0]                 w_winner;
   logic                                  w_found;

   // A new entry is younger than everything already occupied; slot 1 is younger than slot 0.
   always_comb begin
      // NOTE: each always_comb output gets a full default first, so no latch can be inferred.
      w_age_next = r_age;
      if (i_alloc0_valid) begin
         w_age_next[i_alloc0_idx] = '0;
         for (int k = 0; k < QUEUE_SIZE; k++) begin
            w_age_next[k][i_alloc0_idx] = i_entry_occupied[k];
         end
      end
      if (i_alloc1_valid) begin
         w_age_next[i_alloc1_idx] = '0;
         for (int k = 0; k < QUEUE_SIZE; k++) begin
            w_age_next[k][i_alloc1_idx] = i_entry_occupied[k] |
               (i_alloc0_valid && (k == int'(i_alloc0_idx)));
         end
      end
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         w_age_next[i][i] = 1'b0;
      end
   end

   // NOTE: state registers take non-blocking assignments; the matrix is a small flop array
   // (not RAM), so it is cleared outright on reset and flush.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_age <= '0;
      end else begin
         r_age <= w_age_next;
      end
   end

   always_comb begin
      w_cand   = i_entry_occupied & i_entry_ready;
      w_winner = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         w_winner[i] = w_cand[i];
         for (int k = 0; k < QUEUE_SIZE; k++) begin
            if (w_cand[k] && r_age[k][i]) w_winner[i] = 1'b0;
         end
      end
   end

   // Lowest index breaks a tie, which only a corrupt matrix can produce.
   always_comb begin
      w_found   = 1'b0;
      o_win_idx = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (w_winner[i] && !w_found) begin
            w_found   = 1'b1;
            o_win_idx = QUEUE_INDEX'(i);
         end
      end
   end

   assign o_any_cand = |w_cand;

   a_alloc_idx_distinct : assert property (@(posedge clk) disable iff (rst)
      !(i_alloc0_valid && i_alloc1_valid && (i_alloc0_idx == i_alloc1_idx)));

endmodule

// File: rtl/int_issue_select.sv
// Oldest-first select/issue scheduler: picks the oldest ready entry and holds it in a
// one-entry issue register handshaking with the ALU stage.
module int_issue_select
   import int_issue_select_pkg::*;
#(
   parameter int QUEUE_SIZE  = INT_QUEUE_SIZE,
   parameter int QUEUE_INDEX = INT_QUEUE_SIZE_INDEX
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [QUEUE_SIZE-1:0]  entry_occupied,
   input  logic [QUEUE_SIZE-1:0]  entry_ready,
   input  logic                   alloc0_valid,
   input  logic [QUEUE_INDEX-1:0] alloc0_idx,
   input  logic                   alloc1_valid,
   input  logic [QUEUE_INDEX-1:0] alloc1_idx,
   input  logic                   flush,
   input  logic                   issue_ready,
   output logic                   issue_valid,
   output logic [QUEUE_INDEX-1:0] issue_idx,
   output logic                   dealloc_valid,
   output logic [QUEUE_INDEX-1:0] dealloc_idx
);

   logic                   w_any_cand;
   logic [QUEUE_INDEX-1:0] w_win_idx;
   logic                   w_cap;
   logic                   r_issue_valid;
   logic [QUEUE_INDEX-1:0] r_issue_idx;

   int_issue_select_age_matrix_select #(
      .QUEUE_SIZE  (QUEUE_SIZE),
      .QUEUE_INDEX (QUEUE_INDEX)
   ) u_age_matrix_select (
      .clk              (clk),
      .rst              (rst),
      .i_entry_occupied (entry_occupied),
      .i_entry_ready    (entry_ready),
      .i_alloc0_valid   (alloc0_valid),
      .i_alloc0_idx     (alloc0_idx),
      .i_alloc1_valid   (alloc1_valid),
      .i_alloc1_idx     (alloc1_idx),
      .i_flush          (flush),
      .o_any_cand       (w_any_cand),
      .o_win_idx        (w_win_idx)
   );

   // Capture only when the register is empty or being drained this cycle.
   assign w_cap = w_any_cand & (~r_issue_valid | issue_ready) & ~flush & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_valid <= 1'b0;
         r_issue_idx   <= '0;
      end else if (flush) begin
         r_issue_valid <= 1'b0;
      end else if (w_cap) begin
         r_issue_valid <= 1'b1;
         r_issue_idx   <= w_win_idx;
      end else if (issue_ready) begin
         r_issue_valid <= 1'b0;
      end
   end

   assign issue_valid   = r_issue_valid;
   assign issue_idx     = r_issue_idx;
   assign dealloc_valid = w_cap;
   assign dealloc_idx   = w_win_idx;

endmodule

// File: tb/tb_int_issue_select.sv
// Bench for int_issue_select: directed plan steps then random traffic, all checked
// against an allocation-sequence-number model of the queue and issue register.
module tb_int_issue_select;
   import int_issue_select_pkg::*;

   localparam int QS = INT_QUEUE_SIZE;
   localparam int QI = INT_QUEUE_SIZE_INDEX;

   logic          clk = 1'b0;
   logic          rst;
   logic [QS-1:0] entry_occupied;
   logic [QS-1:0] entry_ready;
   logic          alloc0_valid;
   logic [QI-1:0] alloc0_idx;
   logic          alloc1_valid;
   logic [QI-1:0] alloc1_idx;
   logic          flush;
   logic          issue_ready;
   logic          issue_valid;
   logic [QI-1:0] issue_idx;
   logic          dealloc_valid;
   logic [QI-1:0] dealloc_idx;

   int_issue_select dut (
      .clk            (clk),
      .rst            (rst),
      .entry_occupied (entry_occupied),
      .entry_ready    (entry_ready),
      .alloc0_valid   (alloc0_valid),
      .alloc0_idx     (alloc0_idx),
      .alloc1_valid   (alloc1_valid),
      .alloc1_idx     (alloc1_idx),
      .flush          (flush),
      .issue_ready    (issue_ready),
      .issue_valid    (issue_valid),
      .issue_idx      (issue_idx),
      .dealloc_valid  (dealloc_valid),
      .dealloc_idx    (dealloc_idx)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: occupancy plus a global allocation sequence number per entry (smaller = older).
   bit [QS-1:0] m_occ;
   int unsigned m_seq [QS];
   int unsigned m_next_seq;
   bit          m_iv;
   int          m_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_winner();
      int best = -1;
      for (int i = 0; i < QS; i++) begin
         if (m_occ[i] && entry_ready[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
      end
      return best;
   endfunction

   // One clock: check the combinational pick before the edge, advance the model, check registers.
   task automatic step();
      int w;
      bit cap;
      entry_occupied = m_occ;
      #1;
      w   = model_winner();
      cap = (w >= 0) && (!m_iv || issue_ready) && !flush && !rst;
      check("dealloc_valid", dealloc_valid, cap);
      if (cap) check("dealloc_idx", dealloc_idx, w);
      @(posedge clk);
      if (rst) begin
         m_iv = 1'b0; m_idx = 0; m_occ = '0;
      end else if (flush) begin
         m_iv = 1'b0; m_occ = '0;
      end else begin
         if (cap) begin
            m_iv = 1'b1; m_idx = w; m_occ[w] = 1'b0;
         end else if (issue_ready) begin
            m_iv = 1'b0;
         end
         if (alloc0_valid) begin
            m_occ[alloc0_idx] = 1'b1; m_seq[alloc0_idx] = m_next_seq++;
         end
         if (alloc1_valid) begin
            m_occ[alloc1_idx] = 1'b1; m_seq[alloc1_idx] = m_next_seq++;
         end
      end
      @(negedge clk);
      check("issue_valid", issue_valid, m_iv);
      if (m_iv || rst) check("issue_idx", issue_idx, m_idx);
   endtask

   task automatic idle_allocs();
      alloc0_valid = 1'b0; alloc1_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic expect_issue(input string tag, input int idx);
      check({tag, "_valid"}, issue_valid, 1);
      check({tag, "_idx"}, issue_idx, idx);
   endtask

   initial begin
      int free_list[$];
      int j;
      m_occ = '0; m_next_seq = 0; m_iv = 1'b0; m_idx = 0;
      rst = 1'b1; entry_ready = '0; issue_ready = 1'b1;
      alloc0_idx = '0; alloc1_idx = '0;
      idle_allocs();
      @(negedge clk);
      step(); step();
      check("reset_valid", issue_valid, 0);
      check("reset_idx", issue_idx, 0);
      rst = 1'b0;

      // Plan 1: alloc entry 5, ready next cycle.
      alloc0_valid = 1'b1; alloc0_idx = 3'd5; step();
      idle_allocs(); entry_ready = 8'h20; step();
      expect_issue("p1_issue", 5);
      entry_ready = '0;

      // Plan 2: allocate 2, 0, 7 on successive cycles; all ready at cycle 4.
      alloc0_valid = 1'b1; alloc0_idx = 3'd2; step();
      alloc0_idx = 3'd0; step();
      alloc0_idx = 3'd7; step();
      idle_allocs(); step();
      entry_ready = 8'hFF; step(); expect_issue("p2_first", 2);
      step(); expect_issue("p2_second", 0);
      step(); expect_issue("p2_third", 7);
      entry_ready = '0; step();

      // Plan 3: same-cycle alloc, slot 0 older.
      alloc0_valid = 1'b1; alloc0_idx = 3'd6; alloc1_valid = 1'b1; alloc1_idx = 3'd1; step();
      idle_allocs(); entry_ready = 8'hFF; step(); expect_issue("p3_first", 6);
      step(); expect_issue("p3_second", 1);
      entry_ready = '0; step();

      // Plan 4: oldest not ready, younger ready entry overtakes.
      alloc0_valid = 1'b1; alloc0_idx = 3'd3; step();
      alloc0_idx = 3'd4; step();
      idle_allocs(); entry_ready = 8'h10; step(); expect_issue("p4_young", 4);
      entry_ready = 8'h08; step(); expect_issue("p4_old", 3);
      entry_ready = '0; step();

      // Plan 5: three-cycle stall while entry 1 waits.
      alloc0_valid = 1'b1; alloc0_idx = 3'd6; alloc1_valid = 1'b1; alloc1_idx = 3'd1; step();
      idle_allocs(); entry_ready = 8'hFF; step(); expect_issue("p5_first", 6);
      issue_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step(); expect_issue("p5_hold", 6);
      end
      issue_ready = 1'b1; step(); expect_issue("p5_release", 1);
      entry_ready = '0; step();

      // Plan 6: flush with a held instruction and two ready entries; alloc in flush cycle ignored.
      alloc0_valid = 1'b1; alloc0_idx = 3'd3; alloc1_valid = 1'b1; alloc1_idx = 3'd5; step();
      alloc1_valid = 1'b0; alloc0_idx = 3'd6; step();
      idle_allocs(); entry_ready = 8'hFF; issue_ready = 1'b0; step(); expect_issue("p6_held", 3);
      flush = 1'b1; issue_ready = 1'b1; alloc0_valid = 1'b1; alloc0_idx = 3'd4; step();
      check("p6_flush_valid", issue_valid, 0);
      idle_allocs(); entry_ready = '0; alloc0_valid = 1'b1; alloc0_idx = 3'd2; step();
      idle_allocs(); entry_ready = 8'h04; step(); expect_issue("p6_fresh", 2);
      entry_ready = '0; step();

      // Queue full with nothing ready: no capture, then drain strictly in allocation order.
      for (int p = 0; p < QS; p += 2) begin
         alloc0_valid = 1'b1; alloc0_idx = QI'(p); alloc1_valid = 1'b1; alloc1_idx = QI'(p + 1);
         step();
      end
      idle_allocs(); step(); step();
      check("full_no_issue", issue_valid, 0);
      entry_ready = 8'hFF;
      for (int p = 0; p < QS; p++) begin
         step(); expect_issue("full_drain", p);
      end
      entry_ready = '0; step();

      // Reset during a stall discards the held entry.
      alloc0_valid = 1'b1; alloc0_idx = 3'd3; step();
      idle_allocs(); entry_ready = 8'hFF; issue_ready = 1'b0; step(); expect_issue("rst_held", 3);
      step();
      rst = 1'b1; step();
      check("rst_stall_valid", issue_valid, 0);
      check("rst_stall_idx", issue_idx, 0);
      rst = 1'b0; entry_ready = '0; issue_ready = 1'b1;

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         rst         = ($urandom_range(0, 199) == 0);
         flush       = ($urandom_range(0, 99) < 3);
         issue_ready = ($urandom_range(0, 3) != 0);
         entry_ready = QS'($urandom) & QS'($urandom);
         free_list.delete();
         for (int i = 0; i < QS; i++) if (!m_occ[i]) free_list.push_back(i);
         alloc0_valid = 1'b0; alloc1_valid = 1'b0;
         if (free_list.size() > 0 && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, free_list.size() - 1);
            alloc0_valid = 1'b1; alloc0_idx = QI'(free_list[j]); free_list.delete(j);
         end
         if (free_list.size() > 0 && $urandom_range(0, 2) == 0) begin
            j = $urandom_range(0, free_list.size() - 1);
            alloc1_valid = 1'b1; alloc1_idx = QI'(free_list[j]); free_list.delete(j);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
